mealy_seq_det: RTL and testbench



---
 rtl/mealy_seq_pkg.sv | 14 +
 rtl/sat_counter.sv | 34 +++
 rtl/mealy_seq_det.sv | 158 +++++++++++++++
 tb/tb_mealy_seq_det.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_seq_pkg.sv
// Shared types and default widths for the programmable Mealy sequence detector.
package mealy_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_ARMED = 2'b10
    } state_e;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned LEN_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment in one cycle yields 1.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/mealy_seq_det.sv
// Run-time programmable serial pattern detector (1..PAT_W bits) with overlap control,
// optional registered output and a saturating match counter.
module mealy_seq_det
    import mealy_seq_pkg::*;
#(
    parameter int unsigned PAT_W   = PAT_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             x_vld,
    input  logic             x,
    output logic             y,
    output logic             busy,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             clr_cnt
);

    localparam int unsigned HW = PAT_W - 1;

    state_e           state_q, state_d;
    logic [HW-1:0]    hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             cfg_err_q, cfg_err_d;

    logic [LEN_W-1:0] len_m1;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             match_c;

    assign len_m1 = len_q - LEN_W'(1);
    assign window = {hist_q, x};
    assign mask   = ~({PAT_W{1'b1}} << len_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cfg_err_d = cfg_err_q;

        if (!en) begin
            state_d = ST_IDLE;
            fill_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pat_d  = cfg_pat;
                    len_d  = cfg_len;
                    ovl_d  = cfg_ovl;
                    hist_d = '0;
                    fill_d = '0;
                    if ((cfg_len == '0) || (cfg_len > LEN_W'(PAT_W))) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        state_d   = ST_FILL;
                    end
                end
                ST_FILL, ST_ARMED: begin
                    if (x_vld) begin
                        if (match_c && !ovl_q) begin
                            // Non-overlap: restart the search from an empty history
                            hist_d  = '0;
                            fill_d  = '0;
                            state_d = (len_q == LEN_W'(1)) ? ST_ARMED : ST_FILL;
                        end else begin
                            hist_d = HW'({hist_q, x});
                            if (fill_q >= len_m1) begin
                                fill_d  = len_m1;
                                state_d = ST_ARMED;
                            end else begin
                                fill_d = fill_q + LEN_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // Mealy match: masked compare of newest len bits against the latched pattern
    always_comb begin
        match_c = 1'b0;
        if (((state_q == ST_FILL) || (state_q == ST_ARMED)) && x_vld &&
            (fill_q >= len_m1) && (((window ^ pat_q) & mask) == '0)) begin
            match_c = 1'b1;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_y
            logic y_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    y_q <= 1'b0;
                end else begin
                    y_q <= match_c;
                end
            end
            assign y = y_q;
        end else begin : g_comb_y
            assign y = match_c;
        end
    endgenerate

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (match_c),
        .clr   (clr_cnt),
        .q     (match_cnt)
    );

    assign busy    = (state_q != ST_IDLE);
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_mealy_seq_det.sv
// Directed bench for mealy_seq_det: a Mealy-output instance and a registered-output,
// 2-bit-counter instance share the same stimulus.
module tb_mealy_seq_det;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_ovl;
    logic       x_vld;
    logic       x;
    logic       clr_cnt;

    logic       y_a, busy_a, err_a;
    logic [7:0] cnt_a;
    logic       y_r, busy_r, err_r;
    logic [1:0] cnt_r;

    int n_vec;
    int n_err;

    mealy_seq_det #(
        .PAT_W(8), .LEN_W(4), .CNT_W(8), .REG_OUT(0)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .x_vld(x_vld), .x(x), .y(y_a), .busy(busy_a),
        .cfg_err(err_a), .match_cnt(cnt_a), .clr_cnt(clr_cnt)
    );

    mealy_seq_det #(
        .PAT_W(8), .LEN_W(4), .CNT_W(2), .REG_OUT(1)
    ) dut_r (
        .clk(clk), .rst(rst), .en(en), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .x_vld(x_vld), .x(x), .y(y_r), .busy(busy_r),
        .cfg_err(err_r), .match_cnt(cnt_r), .clr_cnt(clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Disarm and clear counters, then present a new configuration with en=1
    task automatic arm(input logic [7:0] p, input logic [3:0] l, input logic o);
        @(negedge clk);
        en = 1'b0; x_vld = 1'b0; x = 1'b0; clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0; en = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o;
    endtask

    // Present one input cycle; returns 1 time unit after the falling edge
    task automatic cyc(input logic v, input logic b);
        @(negedge clk);
        x_vld = v; x = b;
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_vec++;
        if (y_a !== 1'b0 || busy_a !== 1'b0 || err_a !== 1'b0 || cnt_a !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: y=%b busy=%b err=%b cnt=%0d, want 0 0 0 0", y_a, busy_a, err_a, cnt_a);
        end
        n_vec++;
        if (y_r !== 1'b0 || busy_r !== 1'b0 || cnt_r !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state_r: y=%b busy=%b cnt=%0d, want 0 0 0", y_r, busy_r, cnt_r);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_legacy;
        logic stim [6];
        logic expy [6];
        stim = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        expy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        arm(8'h01, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, stim[i]);
            n_vec++;
            if (y_a !== expy[i]) begin
                n_err++;
                $display("FAIL legacy_y bit%0d: got %b want %b", i + 1, y_a, expy[i]);
            end
        end
        cyc(1'b0, 1'b0);
        n_vec++;
        if (cnt_a !== 8'd2) begin
            n_err++;
            $display("FAIL legacy_cnt: got %0d want 2", cnt_a);
        end
    endtask

    task automatic test_reset_mid;
        arm(8'h01, 4'd2, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        n_vec++;
        if (y_a !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_match: got %b want 1", y_a);
        end
        // Assert reset between edges: outputs must drop without a clock
        rst = 1'b0;
        #1;
        n_vec++;
        if (y_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 8'd0 || cnt_r !== 2'd0) begin
            n_err++;
            $display("FAIL async_reset: y=%b busy=%b cnt_a=%0d cnt_r=%0d, want 0 0 0 0", y_a, busy_a, cnt_a, cnt_r);
        end
        @(negedge clk);
        en = 1'b0; x_vld = 1'b0;
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        n_vec++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b want 0", busy_a);
        end
        en = 1'b1;
        cyc(1'b0, 1'b0);
        n_vec++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_rearm: busy=%b want 1", busy_a);
        end
    endtask

    task automatic test_overlap_modes;
        logic stim [5];
        logic exp_o [5];
        logic exp_n [5];
        stim  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_n = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        arm(8'h05, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, stim[i]);
            n_vec++;
            if (y_a !== exp_o[i]) begin
                n_err++;
                $display("FAIL ovl_y bit%0d: got %b want %b", i + 1, y_a, exp_o[i]);
            end
        end
        cyc(1'b0, 1'b0);
        n_vec++;
        if (cnt_a !== 8'd2) begin
            n_err++;
            $display("FAIL ovl_cnt: got %0d want 2", cnt_a);
        end
        arm(8'h05, 4'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, stim[i]);
            n_vec++;
            if (y_a !== exp_n[i]) begin
                n_err++;
                $display("FAIL novl_y bit%0d: got %b want %b", i + 1, y_a, exp_n[i]);
            end
        end
        cyc(1'b0, 1'b0);
        n_vec++;
        if (cnt_a !== 8'd1) begin
            n_err++;
            $display("FAIL novl_cnt: got %0d want 1", cnt_a);
        end
    endtask

    task automatic test_gaps_reg;
        // Valid bits 1,1,0,0 with gap cycles carrying x=1 that must not shift
        logic vs [8];
        logic bs [8];
        logic exp_a [8];
        logic exp_r [8];
        vs    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bs    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        arm(8'h0C, 4'd4, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(vs[i], bs[i]);
            n_vec++;
            if (y_a !== exp_a[i] || y_r !== exp_r[i]) begin
                n_err++;
                $display("FAIL gap_y cyc%0d: y_a=%b y_r=%b want %b %b", i, y_a, y_r, exp_a[i], exp_r[i]);
            end
        end
        cyc(1'b0, 1'b0);
        n_vec++;
        if (y_r !== 1'b0 || cnt_r !== 2'd1 || cnt_a !== 8'd1) begin
            n_err++;
            $display("FAIL gap_tail: y_r=%b cnt_r=%0d cnt_a=%0d want 0 1 1", y_r, cnt_r, cnt_a);
        end
    endtask

    task automatic test_cfg_err;
        arm(8'h05, 4'd0, 1'b1);
        cyc(1'b0, 1'b0);
        n_vec++;
        if (err_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_len0: err=%b busy=%b want 1 0", err_a, busy_a);
        end
        arm(8'h05, 4'd3, 1'b1);
        cyc(1'b0, 1'b0);
        n_vec++;
        if (err_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_rearm: err=%b busy=%b want 0 1", err_a, busy_a);
        end
        arm(8'h05, 4'd9, 1'b1);
        cyc(1'b0, 1'b0);
        n_vec++;
        if (err_a !== 1'b1 || busy_a !== 1'b0 || err_r !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_len9: err=%b busy=%b err_r=%b want 1 0 1", err_a, busy_a, err_r);
        end
    endtask

    task automatic test_en_drop;
        arm(8'h01, 4'd2, 1'b1);
        cyc(1'b1, 1'b0);
        @(negedge clk);
        en = 1'b0; x_vld = 1'b1; x = 1'b1;
        #1;
        n_vec++;
        if (y_a !== 1'b1) begin
            n_err++;
            $display("FAIL en_drop_y: got %b want 1", y_a);
        end
        cyc(1'b0, 1'b0);
        n_vec++;
        if (busy_a !== 1'b0 || cnt_a !== 8'd1) begin
            n_err++;
            $display("FAIL en_drop_after: busy=%b cnt=%0d want 0 1", busy_a, cnt_a);
        end
    endtask

    task automatic test_saturation;
        arm(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1);
            n_vec++;
            if (y_a !== 1'b1) begin
                n_err++;
                $display("FAIL len1_y bit%0d: got %b want 1", i + 1, y_a);
            end
        end
        cyc(1'b0, 1'b0);
        n_vec++;
        if (cnt_r !== 2'd3 || cnt_a !== 8'd5) begin
            n_err++;
            $display("FAIL sat_cnt: cnt_r=%0d cnt_a=%0d want 3 5", cnt_r, cnt_a);
        end
        @(negedge clk);
        clr_cnt = 1'b1; x_vld = 1'b1; x = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0; x_vld = 1'b0;
        #1;
        n_vec++;
        if (cnt_r !== 2'd1 || cnt_a !== 8'd1) begin
            n_err++;
            $display("FAIL clr_with_match: cnt_r=%0d cnt_a=%0d want 1 1", cnt_r, cnt_a);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0; en = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
        x_vld = 1'b0; x = 1'b0; clr_cnt = 1'b0;
        test_reset;
        test_legacy;
        test_reset_mid;
        test_overlap_modes;
        test_gaps_reg;
        test_cfg_err;
        test_en_drop;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
